mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline. Consumes the EX/MEM pipeline register outputs and performs
//  the data-memory access through a req/ack handshake. Stalls upstream stages while an access is
//  outstanding, resolves the branch (pc_src) and registers the MEM/WB pipeline values.
//  Sits between the EX/MEM pipeline register and the WB stage.
// PARAMETERS
//  ADDR_W   7   data-memory word-address width; dmem_addr = alu_result_reg[ADDR_W+1:2]
//  TIMEOUT  15  max cycles waiting for dmem_ack before abort (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  mem_to_reg_reg  in   1   WB select from EX/MEM: 1 = memory data, 0 = ALU result
//  reg_write_reg   in   1   register-file write enable from EX/MEM
//  branch_reg      in   1   branch instruction flag from EX/MEM
//  mem_write_reg   in   1   store flag from EX/MEM
//  mem_read_reg    in   1   load flag from EX/MEM
//  pc_branch_reg   in   7   branch target from EX/MEM
//  zero_reg        in   1   ALU zero flag from EX/MEM
//  alu_result_reg  in   32  ALU result / effective address from EX/MEM
//  data2_reg       in   32  store data from EX/MEM
//  dst_reg         in   5   destination register from EX/MEM
//  dmem_req        out  1   memory request; held until ack or timeout
//  dmem_we         out  1   1 = write, 0 = read; valid while dmem_req = 1
//  dmem_addr       out  ADDR_W  word address; valid while dmem_req = 1
//  dmem_wdata      out  32  store data; valid while dmem_req = 1
//  dmem_ack        in   1   memory completion, single-cycle pulse
//  dmem_rdata      in   32  read data; valid in the dmem_ack cycle
//  stall           out  1   freezes PC, IF/ID, ID/EX and EX/MEM while high
//  pc_src          out  1   take branch: branch_reg & zero_reg & ~stall
//  pc_branch_out   out  7   branch target, equal to pc_branch_reg
//  err             out  1   sticky flag: memory timeout occurred; cleared only by rst
//  wb_reg_write    out  1   MEM/WB register write enable
//  wb_mem_to_reg   out  1   MEM/WB WB select
//  wb_read_data    out  32  MEM/WB loaded data
//  wb_alu_result   out  32  MEM/WB ALU result
//  wb_dst          out  5   MEM/WB destination register
// BEHAVIOUR
//  - Reset (async, rst = 1):
//    - state = IDLE, wait counter = 0.
//    - All registered outputs = 0, including err and all wb_* outputs.
//    - dmem_req drops immediately, including mid-access. The in-flight instruction is discarded.
//  - access = mem_read_reg | mem_write_reg. If both are set, the access is a write (dmem_we = 1).
//  - FSM states IDLE, REQ, DONE:
//    - IDLE, no access:
//      - stall = 0.
//      - On each edge, the MEM/WB register loads the current instruction (1-cycle latency).
//    - IDLE, access:
//      - stall = 1 combinationally. The MEM/WB register loads a bubble (wb_reg_write = 0).
//      - Next state REQ.
//    - REQ:
//      - dmem_req = 1 and stall = 1. dmem_we, dmem_addr and dmem_wdata come from the held EX/MEM values.
//      - Counter increments each cycle and the MEM/WB register loads a bubble.
//      - dmem_ack = 1: capture dmem_rdata into the read-data hold register, next state DONE.
//      - Counter reaches TIMEOUT with no ack:
//        - Set err, hold data = 0, next state DONE.
//        - dmem_req is low from the next cycle.
//      - Ack and timeout in the same cycle: ack wins and err is not set.
//    - DONE:
//      - stall = 0 and dmem_req = 0.
//      - The MEM/WB register loads the instruction, with wb_read_data = hold data.
//      - For stores, wb_read_data = 0.
//      - Counter cleared. Next state IDLE.
//  - Load latency: the stall spans (IDLE + REQ cycles). The MEM/WB update occurs at the end of DONE.
//  - Access to MEM/WB:
//    - With ack in the first REQ cycle: 3 edges.
//    - Worst case: TIMEOUT + 2 edges.
//  - Back-to-back accesses: DONE -> IDLE sees the next instruction, which re-enters REQ. No idle gap beyond IDLE.
//  - dmem_ack outside REQ is ignored.
//  - pc_src is combinational and forced to 0 while stall = 1.
// TESTING
//  - ALU op, reg_write_reg = 1, alu_result_reg = 0x1234, dst_reg = 5 -> next edge: wb_alu_result = 0x1234,
//    wb_dst = 5, wb_reg_write = 1; stall never asserted.
//  - Load from addr 0x10, ack 2 cycles after dmem_req rises with rdata = 0xDEADBEEF:
//    - dmem_addr = 4, dmem_we = 0, stall high for 3 cycles.
//    - wb_read_data = 0xDEADBEEF; wb_reg_write = 0 during the stall.
//  - Store to addr 0x08 with data2_reg = 0xCAFE, mem_read_reg also set -> dmem_we = 1, dmem_addr = 2,
//    dmem_wdata = 0xCAFE; ack in 1st cycle -> done after 3 edges.
//  - Load, never acked -> dmem_req drops after TIMEOUT = 15 cycles, err = 1 until rst,
//    wb_read_data = 0, pipeline resumes.
//  - branch_reg = 1, zero_reg = 1, pc_branch_reg = 0x2A -> pc_src = 1, pc_branch_out = 0x2A.
//    Same inputs with stall = 1 -> pc_src = 0.
//  - rst pulsed in REQ -> dmem_req, stall, err and wb_* go to 0 without waiting for a clock.
//    FSM = IDLE, and a later ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with req/ack data-memory access, stall, branch resolve and MEM/WB register
module mem_stage #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_to_reg_reg,
  input  logic              reg_write_reg,
  input  logic              branch_reg,
  input  logic              mem_write_reg,
  input  logic              mem_read_reg,
  input  logic [6:0]        pc_branch_reg,
  input  logic              zero_reg,
  input  logic [31:0]       alu_result_reg,
  input  logic [31:0]       data2_reg,
  input  logic [4:0]        dst_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [6:0]        pc_branch_out,
  output logic              err,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [31:0]       wb_read_data,
  output logic [31:0]       wb_alu_result,
  output logic [4:0]        wb_dst
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] hold;
  logic access, tmo;
  assign access        = mem_read_reg | mem_write_reg;
  // Timeout fires in the TIMEOUT-th request cycle; a simultaneous ack takes priority.
  assign tmo           = (state == REQ) & ~dmem_ack & (cnt == CW'(TIMEOUT - 1));
  // Reset gates stall so the pipeline is released immediately, not at the next edge.
  assign stall         = ~rst & (((state == IDLE) & access) | (state == REQ));
  assign dmem_req      = state == REQ;
  assign dmem_we       = mem_write_reg;
  assign dmem_addr     = alu_result_reg[ADDR_W+1:2];
  assign dmem_wdata    = data2_reg;
  assign pc_src        = branch_reg & zero_reg & ~stall;
  assign pc_branch_out = pc_branch_reg;
  // Next-state selection for the access sequencer.
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (access ? REQ : IDLE) :
               (state == REQ)  ? ((dmem_ack | tmo) ? DONE : REQ) : IDLE;
  end
  // State, wait counter, read-data hold and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == REQ) ? cnt + 1'b1 : '0;
      hold  <= ((state == REQ) & dmem_ack) ? dmem_rdata : tmo ? '0 : hold;
      err   <= err | tmo;
    end
  end
  // MEM/WB register: bubble while stalled, otherwise the current instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_dst        <= '0;
    end else begin
      wb_reg_write  <= stall ? 1'b0 : reg_write_reg;
      wb_mem_to_reg <= stall ? 1'b0 : mem_to_reg_reg;
      wb_read_data  <= (state == DONE & ~mem_write_reg) ? hold : '0;
      wb_alu_result <= stall ? '0 : alu_result_reg;
      wb_dst        <= stall ? '0 : dst_reg;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a transaction-level model
module tb_mem_stage;
  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 15;
  typedef struct {
    logic        mtr, rw, br, mw, mr, z;
    logic [6:0]  pcb;
    logic [31:0] alu, d2;
    logic [4:0]  dst;
  } ins_t;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_to_reg_reg, reg_write_reg, branch_reg, mem_write_reg, mem_read_reg, zero_reg;
  logic [6:0] pc_branch_reg, pc_branch_out;
  logic [31:0] alu_result_reg, data2_reg, dmem_wdata, dmem_rdata, wb_read_data, wb_alu_result;
  logic [4:0] dst_reg, wb_dst;
  logic dmem_req, dmem_we, dmem_ack, stall, pc_src, err, wb_reg_write, wb_mem_to_reg;
  logic [ADDR_W-1:0] dmem_addr;
  int passed = 0, total = 0;
  logic err_exp = 1'b0;
  mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mem_to_reg_reg(mem_to_reg_reg), .reg_write_reg(reg_write_reg),
    .branch_reg(branch_reg), .mem_write_reg(mem_write_reg), .mem_read_reg(mem_read_reg),
    .pc_branch_reg(pc_branch_reg), .zero_reg(zero_reg), .alu_result_reg(alu_result_reg),
    .data2_reg(data2_reg), .dst_reg(dst_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_branch_out(pc_branch_out), .err(err),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_dst(wb_dst)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic drive(input ins_t i);
    mem_to_reg_reg = i.mtr; reg_write_reg = i.rw; branch_reg = i.br; mem_write_reg = i.mw;
    mem_read_reg = i.mr; zero_reg = i.z; pc_branch_reg = i.pcb; alu_result_reg = i.alu;
    data2_reg = i.d2; dst_reg = i.dst;
  endtask
  function automatic ins_t rnd_ins(input bit acc);
    ins_t i;
    i.mtr = 1'($urandom); i.rw = 1'($urandom); i.br = 1'($urandom); i.z = 1'($urandom);
    i.mw = acc & 1'($urandom); i.mr = acc & (~i.mw | 1'($urandom));
    i.pcb = 7'($urandom); i.alu = $urandom; i.d2 = $urandom; i.dst = 5'($urandom);
    return i;
  endfunction
  // Runs one instruction starting in the low clock phase; d = ack index in REQ (1..TIMEOUT), else never.
  task automatic run(input ins_t i, input int d, input logic [31:0] rd);
    bit acked;
    int n;
    logic [31:0] rd_exp;
    drive(i);
    if (!(i.mr | i.mw)) begin
      dmem_ack = 1'b0;
      #1;
      chk("alu_stall", 32'(stall), 0);
      chk("alu_pc_src", 32'(pc_src), 32'(i.br & i.z));
      chk("alu_pc_branch_out", 32'(pc_branch_out), 32'(i.pcb));
      @(negedge clk);
      rd_exp = 0;
    end else begin
      acked = d >= 1 && d <= TIMEOUT;
      n = acked ? d : TIMEOUT;
      dmem_ack = 1'b1;
      dmem_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(stall), 1);
      chk("idle_req", 32'(dmem_req), 0);
      chk("idle_pc_src", 32'(pc_src), 0);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        dmem_ack = (k == d);
        dmem_rdata = (k == d) ? rd : $urandom;
        #1;
        chk("req_req", 32'(dmem_req), 1);
        chk("req_stall", 32'(stall), 1);
        chk("req_we", 32'(dmem_we), 32'(i.mw));
        chk("req_addr", 32'(dmem_addr), i.alu / 4 % (1 << ADDR_W));
        chk("req_wdata", dmem_wdata, i.d2);
        chk("req_pc_src", 32'(pc_src), 0);
        chk("req_wb_reg_write", 32'(wb_reg_write), 0);
      end
      @(negedge clk);
      dmem_ack = 1'b1;
      dmem_rdata = $urandom;
      if (!acked) err_exp = 1'b1;
      #1;
      chk("done_req", 32'(dmem_req), 0);
      chk("done_stall", 32'(stall), 0);
      chk("done_pc_src", 32'(pc_src), 32'(i.br & i.z));
      @(negedge clk);
      dmem_ack = 1'b0;
      rd_exp = (i.mw || !acked) ? 0 : rd;
    end
    chk("wb_reg_write", 32'(wb_reg_write), 32'(i.rw));
    chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(i.mtr));
    chk("wb_read_data", wb_read_data, rd_exp);
    chk("wb_alu_result", wb_alu_result, i.alu);
    chk("wb_dst", 32'(wb_dst), 32'(i.dst));
    chk("err", 32'(err), 32'(err_exp));
  endtask
  initial begin
    ins_t i;
    i = '{default: '0};
    drive(i);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wb", {wb_reg_write, wb_mem_to_reg, 30'(wb_dst)}, 0);
    chk("rst_wb_data", wb_read_data | wb_alu_result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    i = '{default: '0}; i.rw = 1; i.alu = 32'h1234; i.dst = 5;
    run(i, 0, 0);
    i = '{default: '0}; i.rw = 1; i.mtr = 1; i.mr = 1; i.alu = 32'h10; i.dst = 7;
    run(i, 2, 32'hDEADBEEF);
    i = '{default: '0}; i.mw = 1; i.mr = 1; i.alu = 32'h08; i.d2 = 32'hCAFE;
    run(i, 1, 32'h5555AAAA);
    i = '{default: '0}; i.br = 1; i.z = 1; i.pcb = 7'h2A;
    run(i, 0, 0);
    i.mr = 1;
    run(i, TIMEOUT, 32'h0BADF00D);
    i = '{default: '0}; i.rw = 1; i.mr = 1; i.alu = 32'h1FC; i.dst = 3;
    run(i, TIMEOUT + 5, 32'h12345678);
    i = '{default: '0}; i.rw = 1; i.alu = 32'h77;
    run(i, 0, 0);
    for (int t = 0; t < 40; t++) run(rnd_ins(1'($urandom)), int'($urandom_range(0, TIMEOUT + 2)), $urandom);
    i = '{default: '0}; i.rw = 1; i.mr = 1; i.alu = 32'h40;
    drive(i);
    #1;
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(dmem_req), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(dmem_req), 0);
    chk("async_rst_stall", 32'(stall), 0);
    chk("async_rst_err", 32'(err), 0);
    chk("async_rst_wb", {wb_reg_write, wb_mem_to_reg, 30'(wb_dst)}, 0);
    chk("async_rst_wb_data", wb_read_data | wb_alu_result, 0);
    err_exp = 1'b0;
    i = '{default: '0};
    drive(i);
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("post_rst_ack_req", 32'(dmem_req), 0);
    chk("post_rst_ack_data", wb_read_data, 0);
    chk("post_rst_ack_err", 32'(err), 0);
    @(negedge clk);
    for (int t = 0; t < 15; t++) run(rnd_ins(1'($urandom)), int'($urandom_range(1, TIMEOUT)), $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
